// File: rtl/sync_fifo_flagged.sv
// Parametrised single-clock FIFO with registered occupancy flags, two-stage registered
// read path and sticky overflow/underflow error flags.
module sync_fifo_flagged #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] rd_buf;
    logic             rd_pend;

    logic             rd_acc_c;
    logic             wr_acc_c;
    logic [CNT_W-1:0] count_next_c;

    // Acceptance and next occupancy; flags are derived from count_next_c so they align with count.
    always_comb begin
        rd_acc_c     = rd_en & ~empty;
        wr_acc_c     = wr_en & (~full | rd_acc_c);
        count_next_c = count;
        if (wr_acc_c && !rd_acc_c) begin
            count_next_c = count + CNT_W'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            count_next_c = count - CNT_W'(1);
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Head word is captured at the accepting edge so a same-edge write into the freed slot cannot corrupt it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_buf       <= '0;
            rd_pend      <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                rd_buf <= mem[rd_ptr];
            end
            rd_pend  <= rd_acc_c;
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= rd_buf;
            end
            count        <= count_next_c;
            full         <= (count_next_c == CNT_W'(DEPTH));
            empty        <= (count_next_c == '0);
            almost_full  <= (count_next_c >= CNT_W'(AF_LEVEL));
            almost_empty <= (count_next_c <= CNT_W'(AE_LEVEL));
            overflow     <= (wr_en & ~wr_acc_c) | (overflow & ~clr_err);
            underflow    <= (rd_en & ~rd_acc_c) | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed self-checking bench for sync_fifo_flagged at WIDTH=8, DEPTH=4, default levels.
module tb_sync_fifo_flagged;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo_flagged #(.WIDTH(8), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample #1 after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [2:0] cnt);
        check_eq({tag, ".rd_valid"}, 32'(v), 32'(rd_valid));
        if (v) check_eq({tag, ".rd_data"}, 32'(rd_data), 32'(d));
        check_eq({tag, ".count"}, 32'(count), 32'(cnt));
    endtask

    initial begin
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        check_eq("rst.count", 32'(count), 32'd0);
        check_eq("rst.empty", 32'(empty), 32'd1);
        check_eq("rst.almost_empty", 32'(almost_empty), 32'd1);
        check_eq("rst.full", 32'(full), 32'd0);
        check_eq("rst.almost_full", 32'(almost_full), 32'd0);
        check_eq("rst.rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst.rd_data", 32'(rd_data), 32'd0);
        check_eq("rst.overflow", 32'(overflow), 32'd0);
        check_eq("rst.underflow", 32'(underflow), 32'd0);

        // Fill
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        check_eq("fill1.count", 32'(count), 32'd1);
        check_eq("fill1.empty", 32'(empty), 32'd0);
        check_eq("fill1.almost_empty", 32'(almost_empty), 32'd1);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        check_eq("fill2.count", 32'(count), 32'd2);
        check_eq("fill2.almost_empty", 32'(almost_empty), 32'd0);
        check_eq("fill2.almost_full", 32'(almost_full), 32'd0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        check_eq("fill3.count", 32'(count), 32'd3);
        check_eq("fill3.almost_full", 32'(almost_full), 32'd1);
        check_eq("fill3.full", 32'(full), 32'd0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0);
        check_eq("fill4.count", 32'(count), 32'd4);
        check_eq("fill4.full", 32'(full), 32'd1);

        // Drain
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("drain1", 1'b0, 8'h00, 3'd3);
        check_eq("drain1.full", 32'(full), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("drain2", 1'b1, 8'h11, 3'd2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("drain3", 1'b1, 8'h22, 3'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("drain4", 1'b1, 8'h33, 3'd0);
        check_eq("drain4.empty", 32'(empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0); chk_out("drain5", 1'b1, 8'h44, 3'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0); chk_out("drain6", 1'b0, 8'h00, 3'd0);
        check_eq("drain6.hold", 32'(rd_data), 32'h44);

        // Wrap-around: six words, interleaved reads, at most four outstanding
        cyc(1'b1, 8'hA0, 1'b0, 1'b0);
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0); chk_out("wrap0", 1'b0, 8'h00, 3'd3);
        cyc(1'b1, 8'hA3, 1'b1, 1'b0); chk_out("wrap1", 1'b0, 8'h00, 3'd3);
        cyc(1'b1, 8'hA4, 1'b1, 1'b0); chk_out("wrap2", 1'b1, 8'hA0, 3'd3);
        cyc(1'b1, 8'hA5, 1'b1, 1'b0); chk_out("wrap3", 1'b1, 8'hA1, 3'd3);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("wrap4", 1'b1, 8'hA2, 3'd2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("wrap5", 1'b1, 8'hA3, 3'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("wrap6", 1'b1, 8'hA4, 3'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0); chk_out("wrap7", 1'b1, 8'hA5, 3'd0);

        // Simultaneous read/write at full
        cyc(1'b1, 8'hB1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0);
        cyc(1'b1, 8'hB3, 1'b0, 1'b0);
        cyc(1'b1, 8'hB4, 1'b0, 1'b0); chk_out("sfull0", 1'b0, 8'h00, 3'd4);
        cyc(1'b1, 8'h55, 1'b1, 1'b0); chk_out("sfull1", 1'b0, 8'h00, 3'd4);
        check_eq("sfull1.overflow", 32'(overflow), 32'd0);
        check_eq("sfull1.full", 32'(full), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("sfull2", 1'b1, 8'hB1, 3'd3);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("sfull3", 1'b1, 8'hB2, 3'd2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("sfull4", 1'b1, 8'hB3, 3'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("sfull5", 1'b1, 8'hB4, 3'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0); chk_out("sfull6", 1'b1, 8'h55, 3'd0);

        // Simultaneous read/write at empty: read rejected, write accepted
        cyc(1'b1, 8'h66, 1'b1, 1'b0); chk_out("sempty0", 1'b0, 8'h00, 3'd1);
        check_eq("sempty0.underflow", 32'(underflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0); chk_out("sempty1", 1'b0, 8'h00, 3'd1);
        check_eq("sempty1.underflow_sticky", 32'(underflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("sempty2.underflow_clr", 32'(underflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("sempty3", 1'b0, 8'h00, 3'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0); chk_out("sempty4", 1'b1, 8'h66, 3'd0);

        // Overflow at full, sticky until clr_err
        cyc(1'b1, 8'hC0, 1'b0, 1'b0);
        cyc(1'b1, 8'hC1, 1'b0, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0); chk_out("ovf0", 1'b0, 8'h00, 3'd4);
        check_eq("ovf0.overflow", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("ovf1.overflow_sticky", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("ovf2", 1'b1, 8'hC0, 3'd2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("ovf3", 1'b1, 8'hC1, 3'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("ovf4", 1'b1, 8'hC2, 3'd0);
        // clr_err with a new underflow: overflow clears, underflow sets
        cyc(1'b0, 8'h00, 1'b1, 1'b1); chk_out("clr0", 1'b1, 8'hC3, 3'd0);
        check_eq("clr0.overflow", 32'(overflow), 32'd0);
        check_eq("clr0.underflow", 32'(underflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("clr1.underflow_setwins", 32'(underflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("clr2.underflow", 32'(underflow), 32'd0);

        // Reset mid-stream with a read in flight
        cyc(1'b1, 8'hD0, 1'b0, 1'b0);
        cyc(1'b1, 8'hD1, 1'b0, 1'b0);
        cyc(1'b1, 8'hD2, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("mrst0", 1'b0, 8'h00, 3'd2);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        chk_out("mrst1", 1'b0, 8'h00, 3'd0);
        check_eq("mrst1.empty", 32'(empty), 32'd1);
        check_eq("mrst1.rd_data", 32'(rd_data), 32'd0);
        cyc(1'b1, 8'hA5, 1'b0, 1'b0); chk_out("mrst2", 1'b0, 8'h00, 3'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk_out("mrst3", 1'b0, 8'h00, 3'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0); chk_out("mrst4", 1'b1, 8'hA5, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flagged.md
# sync_fifo_flagged

Parametrised synchronous single-clock FIFO. It generalises the team's fixed 8-bit, 4-deep FIFO with registered full/empty flags. It adds configurable width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, write-through-on-full when a read happens in the same cycle, and sticky overflow/underflow error flags. It sits between producer and consumer datapath stages and is checked in formal against an OVL FIFO checker.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 4, number of entries; power of two, >=2
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data, sampled when a write is accepted
- rd_en  in  1  read request
- clr_err  in  1  clears overflow/underflow
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  rd_data holds a newly popped word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_acc). A write is accepted at full only when a read is accepted in the same cycle.
- At empty, a simultaneous read and write: the read is rejected (no fall-through), the write is accepted, and count becomes 1.
- Storage is a DEPTH-entry array indexed by wr_ptr and rd_ptr, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. Occupancy is tracked by count, not by pointer compare.
- Count update:
  - write only: +1
  - read only: -1
  - both or neither: unchanged
  - count never exceeds DEPTH and never goes below 0.
- All flags are registered and computed from the next value of count, so they are valid in the same cycle as count.
- overflow sets on wr_en & !wr_acc. underflow sets on rd_en & !rd_acc.
  - Both flags clear on clr_err.
  - If clr_err and a new error occur in the same cycle, set wins.
- The memory array is not reset; contents after reset are don't-care and never observable.

## Timing
- Reset values (the cycle after rst is sampled high):
  - count=0, empty=1, almost_empty=1, full=0
  - almost_full=0
  - rd_valid=0, rd_data=0, overflow=0, underflow=0
  - wr_ptr=rd_ptr=0
- Write latency: wr_data accepted at edge N is in storage after N. Count and flags reflect it from N onward. It is readable by a read request in cycle N+1.
- Read latency: read accepted at edge N → rd_data = head word and rd_valid=1 after edge N+1. rd_valid stays high for exactly one cycle per accepted read. Back-to-back reads give one word per cycle.
- rd_data holds its last value when rd_valid=0.
- Reset mid-operation: rst dominates all other inputs. Contents are discarded. A rd_valid owed from a read accepted in the cycle before reset is suppressed.
- Inputs are not required to hold after a rejected request. A rejected request has no effect other than setting the error flag.

## Test plan
Unless noted, DEPTH=4, WIDTH=8, default levels.
- Reset then idle: rst high for 2 cycles → count=0, empty=1, almost_empty=1, full=0, rd_valid=0, rd_data=0, no error flags.
- Fill and drain:
  - Write 0x11,0x22,0x33,0x44 on consecutive cycles → count steps 1..4; almost_full at count 3; full at count 4; empty drops after the first write.
  - Read 4 consecutive cycles → rd_data 0x11..0x44 with rd_valid one cycle after each accepted read; empty after the 4th read is accepted.
- Wrap-around: write 6 words and read in interleaved order with at most 4 outstanding → output order matches input order exactly. Both pointers wrap past index 3.
- Simultaneous at boundaries:
  - At full, assert wr_en=rd_en with 0x55 → count stays 4, no overflow, 0x55 is delivered after the three older words.
  - At empty, assert both → underflow=1, count=1, rd_valid stays 0.
- Errors: at full, assert wr_en alone → overflow=1, count stays 4. Sticky until clr_err. clr_err together with a new rd_en on empty → underflow ends at 1.
- Reset mid-stream: with 3 words stored and a read accepted, assert rst → next cycle rd_valid=0, count=0, empty=1. After reset, the first read of a newly written 0xA5 returns 0xA5.
